pipelined_adder_tree: RTL and testbench

Fully pipelined, parameterized binary adder tree that sums `NUM_INPUTS` signed `DATA_WIDTH` samples into one bit-growth-safe result every clock. It sits in high-rate DSP paths (500 MHz class), for example summing parallel lanes of a decimated or polyphase data stream. It accepts a new input vector every cycle and returns results in order with a fixed latency.

---
 rtl/pipelined_adder_tree_pkg.sv | 25 ++
 rtl/pipelined_adder_tree_if.sv | 24 ++
 rtl/pipelined_adder_tree_stage.sv | 45 ++++
 rtl/pipelined_adder_tree.sv | 82 ++++++++
 tb/tb_pipelined_adder_tree.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_tree_pkg.sv
// pipelined_adder_tree_pkg
// Shared sizing helpers for the pipelined adder tree.
// No ports. It provides:
//   tree_depth(n)    : number of adder levels needed to reduce n entries to one
//   out_width(n, w)  : result width that cannot overflow when summing n w-bit samples
//   sum_word_t       : signed sum word for the default 8 x 16-bit build
package pipelined_adder_tree_pkg;

  localparam int DEFAULT_NUM_INPUTS = 8;
  localparam int DEFAULT_DATA_WIDTH = 16;

  function automatic int tree_depth(input int num_inputs);
    return $clog2(num_inputs);
  endfunction

  // Each adder level can grow the sum by one bit, so DEPTH extra bits suffice.
  function automatic int out_width(input int num_inputs, input int data_width);
    return data_width + tree_depth(num_inputs);
  endfunction

  localparam int DEFAULT_OUT_W = out_width(DEFAULT_NUM_INPUTS, DEFAULT_DATA_WIDTH);

  typedef logic signed [DEFAULT_OUT_W-1:0] sum_word_t;

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// pipelined_adder_tree_if
// Streaming bus between a sample source and the adder tree.
//   valid_in  : qualifies data_in this cycle
//   data_in   : NUM_INPUTS flattened signed samples, sample k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_out  : signed sum, DATA_WIDTH + $clog2(NUM_INPUTS) bits
//   valid_out : qualifies data_out
// master = sample source / sink, slave = the adder tree.
interface pipelined_adder_tree_if #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = 16
);
  import pipelined_adder_tree_pkg::*;

  localparam int OUT_W = out_width(NUM_INPUTS, DATA_WIDTH);

  logic                             valid_in;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in;
  logic [OUT_W-1:0]                 data_out;
  logic                             valid_out;

  modport master (output valid_in, output data_in, input data_out, input valid_out);
  modport slave  (input valid_in, input data_in, output data_out, output valid_out);

endinterface

// File: rtl/pipelined_adder_tree_stage.sv
// adder_tree_stage
// One registered level of the adder tree: N_IN entries in, ceil(N_IN/2) sums out.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low clear of all sum registers
//   sum_in  : N_IN entries of WIDTH bits (two's complement)
//   sum_out : registered pairwise sums; an odd trailing entry passes through
module adder_tree_stage #(
  parameter int N_IN  = 2,
  parameter int WIDTH = 19
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_IN-1:0][WIDTH-1:0]            sum_in,
  output logic [(N_IN+1)/2-1:0][WIDTH-1:0]      sum_out
);

  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_OUT-1:0][WIDTH-1:0] sum_d;
  logic [N_OUT-1:0][WIDTH-1:0] sum_q;

  // Inputs are already widened to the final width, so modular addition here
  // is exact signed arithmetic.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (2*k + 1 < N_IN) begin
        sum_d[k] = sum_in[2*k] + sum_in[2*k+1];
      end else begin
        sum_d[k] = sum_in[2*k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
// Fully pipelined signed adder tree: sums NUM_INPUTS samples every clock with
// a fixed latency of DEPTH+1 edges and no backpressure.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears data and valid pipelines
//   bus : slave side of pipelined_adder_tree_if (valid_in/data_in in,
//         data_out/valid_out out, both outputs straight from registers)
module pipelined_adder_tree
  import pipelined_adder_tree_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_adder_tree_if.slave  bus
);

  localparam int DEPTH = tree_depth(NUM_INPUTS);
  localparam int OUT_W = out_width(NUM_INPUTS, DATA_WIDTH);
  localparam int PAD_N = 1 << DEPTH;

  typedef logic [PAD_N-1:0][OUT_W-1:0] level_t;

  // pipe[r][k] is entry k of level r; level r only uses PAD_N >> r entries,
  // the rest are tied to zero so any level can be probed uniformly.
  level_t pipe [DEPTH+1];

  level_t           in0_d;
  level_t           in0_q;
  logic [DEPTH:0]   valid_d;
  logic [DEPTH:0]   valid_q;

  // Stage 0: sign-extend every sample to the output width and pad a
  // non-power-of-2 input count with zero entries.
  always_comb begin
    in0_d = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      in0_d[k] = OUT_W'($signed(bus.data_in[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Valid travels alongside the data; data registers load regardless of valid.
  always_comb begin
    valid_d = {valid_q[DEPTH-1:0], bus.valid_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in0_q   <= '0;
      valid_q <= '0;
    end else begin
      in0_q   <= in0_d;
      valid_q <= valid_d;
    end
  end

  assign pipe[0] = in0_q;

  for (genvar r = 1; r <= DEPTH; r++) begin : g_level
    localparam int N_IN  = PAD_N >> (r - 1);
    localparam int N_OUT = PAD_N >> r;

    logic [N_OUT-1:0][OUT_W-1:0] stage_out;

    adder_tree_stage #(
      .N_IN  (N_IN),
      .WIDTH (OUT_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .sum_in  (pipe[r-1][N_IN-1:0]),
      .sum_out (stage_out)
    );

    assign pipe[r] = {{((PAD_N - N_OUT) * OUT_W){1'b0}}, stage_out};
  end

  assign bus.data_out  = pipe[DEPTH][0];
  assign bus.valid_out = valid_q[DEPTH];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// tb_pipelined_adder_tree
// Directed checks of the adder tree at the default 8 x 16 build plus a
// 5-input build sharing the same clock and reset.
module tb_pipelined_adder_tree;

  logic clk;
  logic rst;

  int compared;
  int mismatched;

  pipelined_adder_tree_if #(.NUM_INPUTS(8), .DATA_WIDTH(16)) bus8 ();
  pipelined_adder_tree_if #(.NUM_INPUTS(5), .DATA_WIDTH(16)) bus5 ();

  pipelined_adder_tree #(.NUM_INPUTS(8), .DATA_WIDTH(16)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  pipelined_adder_tree #(.NUM_INPUTS(5), .DATA_WIDTH(16)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset with random data and valid; outputs must stay cleared.
  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus8.data_in  = {$urandom, $urandom, $urandom, $urandom};
      bus8.valid_in = 1'b1;
      @(posedge clk); #1;
      compared++;
      if (bus8.valid_out !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_valid cycle %0d: got %b want 0", c, bus8.valid_out);
      end
      compared++;
      if (bus8.data_out !== 19'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_data cycle %0d: got %h want 0", c, bus8.data_out);
      end
    end
    @(negedge clk);
    bus8.valid_in = 1'b0;
    bus8.data_in  = '0;
    rst = 1'b1;
  endtask

  // {1..8} for one cycle -> 36, valid exactly on the 4th edge.
  task automatic test_single();
    logic exp_v;
    @(negedge clk);
    for (int k = 0; k < 8; k++) bus8.data_in[k*16 +: 16] = 16'(k + 1);
    bus8.valid_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      bus8.valid_in = 1'b0;
      exp_v = (e == 4);
      compared++;
      if (bus8.valid_out !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL single_valid edge %0d: got %b want %b", e, bus8.valid_out, exp_v);
      end
      if (e == 4) begin
        compared++;
        if (bus8.data_out !== 19'd36) begin
          mismatched++;
          $display("[TB] FAIL single_data: got %0d want 36", $signed(bus8.data_out));
        end
      end
    end
  endtask

  // Back-to-back extremes: all -32768 then all 32767.
  task automatic test_extremes();
    logic exp_v;
    @(negedge clk);
    for (int k = 0; k < 8; k++) bus8.data_in[k*16 +: 16] = 16'h8000;
    bus8.valid_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        for (int k = 0; k < 8; k++) bus8.data_in[k*16 +: 16] = 16'h7FFF;
      end else begin
        bus8.valid_in = 1'b0;
      end
      exp_v = (e == 4) || (e == 5);
      compared++;
      if (bus8.valid_out !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL extreme_valid edge %0d: got %b want %b", e, bus8.valid_out, exp_v);
      end
      if (e == 4) begin
        compared++;
        if (bus8.data_out !== 19'h40000) begin
          mismatched++;
          $display("[TB] FAIL extreme_neg: got %h want 40000", bus8.data_out);
        end
      end
      if (e == 5) begin
        compared++;
        if (bus8.data_out !== 19'd262136) begin
          mismatched++;
          $display("[TB] FAIL extreme_pos: got %0d want 262136", $signed(bus8.data_out));
        end
      end
    end
  endtask

  // 200 cycles, ~70% valid, small samples, scoreboard in order, 20-cycle drain.
  task automatic test_random_stream();
    int exp_q[$];
    int sum;
    int s;
    int exp_sum;
    logic v;
    for (int c = 0; c < 220; c++) begin
      @(negedge clk);
      v = (c < 200) && ($urandom_range(99) < 70);
      sum = 0;
      if (v) begin
        for (int k = 0; k < 8; k++) begin
          s = int'($urandom_range(18)) - 9;
          sum += s;
          bus8.data_in[k*16 +: 16] = 16'(s);
        end
      end else begin
        bus8.data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      bus8.valid_in = v;
      @(posedge clk);
      if (v) exp_q.push_back(sum);
      #1;
      if (bus8.valid_out === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL stream_unexpected cycle %0d: got valid data %0d want no output", c, $signed(bus8.data_out));
        end else begin
          exp_sum = exp_q.pop_front();
          if (bus8.data_out !== 19'(exp_sum)) begin
            mismatched++;
            $display("[TB] FAIL stream_data cycle %0d: got %0d want %0d", c, $signed(bus8.data_out), exp_sum);
          end
        end
      end
    end
    bus8.valid_in = 1'b0;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL stream_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  // Three vectors in flight, reset, then a fresh vector right at release.
  task automatic test_midstream_reset();
    logic exp_v;
    @(negedge clk);
    for (int k = 0; k < 8; k++) bus8.data_in[k*16 +: 16] = 16'(100);
    bus8.valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus8.valid_in = 1'b0;
    #1;
    compared++;
    if (bus8.valid_out !== 1'b0 || bus8.data_out !== 19'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_clear: got valid %b data %h want 0/0", bus8.valid_out, bus8.data_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) bus8.data_in[k*16 +: 16] = 16'(10);
    bus8.valid_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      bus8.valid_in = 1'b0;
      exp_v = (e == 4);
      compared++;
      if (bus8.valid_out !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL midreset_valid edge %0d: got %b want %b", e, bus8.valid_out, exp_v);
      end
      if (e == 4) begin
        compared++;
        if (bus8.data_out !== 19'd80) begin
          mismatched++;
          $display("[TB] FAIL midreset_data: got %0d want 80", $signed(bus8.data_out));
        end
      end
    end
  endtask

  // Five inputs {-1,2,-3,4,-5} -> -3, padded tree keeps latency 4.
  task automatic test_non_pow2();
    logic exp_v;
    @(negedge clk);
    bus5.data_in[0*16 +: 16] = 16'hFFFF;
    bus5.data_in[1*16 +: 16] = 16'd2;
    bus5.data_in[2*16 +: 16] = 16'hFFFD;
    bus5.data_in[3*16 +: 16] = 16'd4;
    bus5.data_in[4*16 +: 16] = 16'hFFFB;
    bus5.valid_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      bus5.valid_in = 1'b0;
      exp_v = (e == 4);
      compared++;
      if (bus5.valid_out !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL pow5_valid edge %0d: got %b want %b", e, bus5.valid_out, exp_v);
      end
      if (e == 4) begin
        compared++;
        if (bus5.data_out !== 19'h7FFFD) begin
          mismatched++;
          $display("[TB] FAIL pow5_data: got %0d want -3", $signed(bus5.data_out));
        end
      end
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b0;
    bus8.valid_in = 1'b0;
    bus8.data_in  = '0;
    bus5.valid_in = 1'b0;
    bus5.data_in  = '0;

    test_reset();
    test_single();
    test_extremes();
    test_random_stream();
    test_midstream_reset();
    test_non_pow2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
